// File: rtl/demux_tree_stream.sv
// demux_tree_stream: pipelined binary-tree stream demultiplexer, 1 input to
// 2**SEL_W outputs. Each pipeline stage resolves one select bit, MSB first, so
// a beat emerges SEL_W cycles after it is accepted. A single global advance
// signal freezes the whole pipe when the addressed consumer is not ready.
//
// Optional feature macro: DEMUX_TREE_DROP_EN
//   When defined, adds dest_en (per-output enable) and drop_cnt (saturating
//   16-bit dropped-beat counter). Beats reaching the last stage for a disabled
//   output are silently consumed instead of presented.

module demux_tree_stream #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic [SEL_W-1:0]        in_sel,
   output logic [(1<<SEL_W)-1:0]   out_valid,
   input  logic [(1<<SEL_W)-1:0]   out_ready,
   output logic [DATA_W-1:0]       out_data
`ifdef DEMUX_TREE_DROP_EN
   ,
   input  logic [(1<<SEL_W)-1:0]   dest_en,
   output logic [15:0]             drop_cnt
`endif
);

   localparam int N    = 1 << SEL_W;
   localparam int LAST = SEL_W - 1;

   // Per-stage state. sel holds the select bits not yet resolved, left
   // aligned so the next bit to resolve is always the MSB. path accumulates
   // resolved bits; at the last stage it equals the full destination index.
   logic [SEL_W-1:0]  vld_q;
   logic [SEL_W-1:0]  vld_d;
   logic [DATA_W-1:0] data_q [SEL_W];
   logic [DATA_W-1:0] data_d [SEL_W];
   logic [SEL_W-1:0]  sel_q  [SEL_W];
   logic [SEL_W-1:0]  sel_d  [SEL_W];
   logic [SEL_W-1:0]  path_q [SEL_W];
   logic [SEL_W-1:0]  path_d [SEL_W];

   logic [SEL_W-1:0]  dest;
   logic [N-1:0]      destOneHot;
   logic              drop;
   logic              present;
   logic              stall;
   logic              advance;

   assign dest       = path_q[LAST];
   assign destOneHot = {{(N-1){1'b0}}, 1'b1} << dest;

`ifdef DEMUX_TREE_DROP_EN
   assign drop = vld_q[LAST] && !dest_en[dest];
`else
   assign drop = 1'b0;
`endif

   // Only the addressed output's ready matters; a dropped beat never stalls.
   assign present   = vld_q[LAST] && !drop;
   assign stall     = present && !out_ready[dest];
   assign advance   = !stall;
   assign in_ready  = advance;
   assign out_valid = present ? destOneHot : '0;
   assign out_data  = data_q[LAST];

   // Next-state of the tree: stage 0 takes the input and resolves the select
   // MSB; every later stage takes its predecessor and resolves one more bit.
   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      sel_d  = sel_q;
      path_d = path_q;
      vld_d[0]  = in_valid;
      data_d[0] = in_data;
      sel_d[0]  = in_sel << 1;
      path_d[0] = SEL_W'(in_sel[SEL_W-1]);
      for (int k = 1; k < SEL_W; k++) begin
         vld_d[k]  = vld_q[k-1];
         data_d[k] = data_q[k-1];
         sel_d[k]  = sel_q[k-1] << 1;
         path_d[k] = (path_q[k-1] << 1) | SEL_W'(sel_q[k-1][SEL_W-1]);
      end
   end

   // Pipeline registers: the whole pipe shifts together or holds together,
   // so bubbles are preserved and outputs stay stable during a stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int k = 0; k < SEL_W; k++) begin
            data_q[k] <= '0;
            sel_q[k]  <= '0;
            path_q[k] <= '0;
         end
      end else if (advance) begin
         vld_q  <= vld_d;
         data_q <= data_d;
         sel_q  <= sel_d;
         path_q <= path_d;
      end
   end

`ifdef DEMUX_TREE_DROP_EN
   logic [15:0] dropCnt_q;

   // Count consumed-but-not-presented beats, sticking at all ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dropCnt_q <= '0;
      end else if (drop && (dropCnt_q != 16'hFFFF)) begin
         dropCnt_q <= dropCnt_q + 16'd1;
      end
   end

   assign drop_cnt = dropCnt_q;
`endif

endmodule
